// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, the decode bundle produced by each axis counter,
// and the constant-evaluation helpers used to size the counters.
package vga_timing_pkg;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock
  localparam int VGA640_H_PIXELS = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_PULSE  = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_PIXELS = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_PULSE  = 2;
  localparam int VGA640_V_BP     = 33;

  // 800x600 @ 60 Hz, 40 MHz pixel clock, positive syncs
  localparam int SVGA800_H_PIXELS = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_PULSE  = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_PIXELS = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_PULSE  = 4;
  localparam int SVGA800_V_BP     = 23;

  typedef struct packed {
    logic active;  // count inside the visible region
    logic sync;    // count inside the sync pulse
    logic first;   // count is zero
  } axis_decode_t;

  function automatic int axis_period(int pixels, int fp, int pulse, int bp);
    return pixels + fp + pulse + bp;
  endfunction

  // Never returns less than 1 so a period of 1 still gets a real register.
  function automatic int clog2_min1(int value);
    int width;
    width = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/vga_timing_controller_axis.sv
// One raster axis: a wrapping period counter plus the active/sync/first decodes
// of its current count. Instantiated once per axis by vga_timing_controller.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int PIXELS = VGA640_H_PIXELS,
  parameter int FP     = VGA640_H_FP,
  parameter int PULSE  = VGA640_H_PULSE,
  parameter int BP     = VGA640_H_BP
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cnt_en,
  output logic [31:0]  count,
  output logic         wrap,
  output axis_decode_t dec
);

  localparam int PERIOD = axis_period(PIXELS, FP, PULSE, BP);
  localparam int W      = clog2_min1(PERIOD);

  localparam logic [W-1:0] LAST    = W'(PERIOD - 1);
  localparam logic [31:0]  ACT_END = 32'(PIXELS);
  localparam logic [31:0]  SYNC_LO = 32'(PIXELS + FP);
  localparam logic [31:0]  SYNC_HI = 32'(PIXELS + FP + PULSE);

  logic [W-1:0] count_q, count_d;

  assign wrap  = (count_q == LAST);
  assign count = 32'(count_q);

  always_comb begin
    count_d = count_q;
    if (cnt_en) count_d = wrap ? '0 : count_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values; the async reset sits in the sensitivity list.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  // Decodes compare at 32 bits so SYNC_HI may equal PERIOD without overflow.
  always_comb begin
    dec        = '0;
    dec.active = (count < ACT_END);
    dec.sync   = (count >= SYNC_LO) && (count < SYNC_HI);
    dec.first  = (count_q == '0);
  end

endmodule

// File: rtl/vga_timing_controller.sv
// VGA raster timing generator: chains a horizontal and a vertical axis counter
// and registers sync, display-enable, coordinates and start pulses (latency 1).
module vga_timing_controller
  import vga_timing_pkg::*;
#(
  parameter int   H_PIXELS = VGA640_H_PIXELS,
  parameter int   H_FP     = VGA640_H_FP,
  parameter int   H_PULSE  = VGA640_H_PULSE,
  parameter int   H_BP     = VGA640_H_BP,
  parameter logic H_POL    = 1'b0,
  parameter int   V_PIXELS = VGA640_V_PIXELS,
  parameter int   V_FP     = VGA640_V_FP,
  parameter int   V_PULSE  = VGA640_V_PULSE,
  parameter int   V_BP     = VGA640_V_BP,
  parameter logic V_POL    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        h_sync,
  output logic        v_sync,
  output logic        disp_ena,
  output logic [31:0] column,
  output logic [31:0] row,
  output logic        frame_start,
  output logic        line_start
);

  logic [31:0]  h_count, v_count;
  logic         h_wrap, v_en;
  logic         v_wrap_unused;  // end-of-frame carry; nothing downstream needs it
  axis_decode_t h_dec, v_dec;

  assign v_en = enable & h_wrap;

  vga_axis_counter #(.PIXELS(H_PIXELS), .FP(H_FP), .PULSE(H_PULSE), .BP(H_BP)) u_h_axis (
    .clk(clk), .reset(reset), .cnt_en(enable),
    .count(h_count), .wrap(h_wrap), .dec(h_dec)
  );

  vga_axis_counter #(.PIXELS(V_PIXELS), .FP(V_FP), .PULSE(V_PULSE), .BP(V_BP)) u_v_axis (
    .clk(clk), .reset(reset), .cnt_en(v_en),
    .count(v_count), .wrap(v_wrap_unused), .dec(v_dec)
  );

  logic        h_sync_q, h_sync_d, v_sync_q, v_sync_d;
  logic        disp_ena_q, disp_ena_d;
  logic [31:0] column_q, column_d, row_q, row_d;
  logic        frame_start_q, frame_start_d, line_start_q, line_start_d;

  // Frozen cycles hold every level output but drop the pulses so none repeats.
  always_comb begin
    h_sync_d      = h_sync_q;
    v_sync_d      = v_sync_q;
    disp_ena_d    = disp_ena_q;
    column_d      = column_q;
    row_d         = row_q;
    frame_start_d = 1'b0;
    line_start_d  = 1'b0;
    if (enable) begin
      h_sync_d      = h_dec.sync ? H_POL : ~H_POL;
      v_sync_d      = v_dec.sync ? V_POL : ~V_POL;
      disp_ena_d    = h_dec.active & v_dec.active;
      frame_start_d = h_dec.first & v_dec.first;
      line_start_d  = h_dec.first & v_dec.active;
      if (h_dec.active && v_dec.active) begin
        column_d = h_count;
        row_d    = v_count;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_sync_q      <= ~H_POL;
      v_sync_q      <= ~V_POL;
      disp_ena_q    <= 1'b0;
      column_q      <= '0;
      row_q         <= '0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
    end else begin
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      disp_ena_q    <= disp_ena_d;
      column_q      <= column_d;
      row_q         <= row_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
    end
  end

  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign disp_ena    = disp_ena_q;
  assign column      = column_q;
  assign row         = row_q;
  assign frame_start = frame_start_q;
  assign line_start  = line_start_q;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Scoreboard bench for vga_timing_controller: a default 640x480 instance and a
// tiny-timing instance share stimulus; a pixel-index model predicts each output.
module tb_vga_timing_controller;

  typedef struct {
    int hpix, hfp, hpul, hbp;
    int vpix, vfp, vpul, vbp;
    bit hpol, vpol;
  } timing_t;

  typedef struct packed {
    logic        hs, vs, de;
    logic [31:0] col, row;
    logic        fs, ls;
  } exp_t;

  typedef struct packed {
    exp_t a;
    exp_t b;
    logic agg;
  } pair_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;

  logic        a_hs, a_vs, a_de, a_fs, a_ls;
  logic [31:0] a_col, a_row;
  logic        b_hs, b_vs, b_de, b_fs, b_ls;
  logic [31:0] b_col, b_row;

  always #5 clk = ~clk;

  vga_timing_controller u_dut (
    .clk(clk), .reset(reset), .enable(enable),
    .h_sync(a_hs), .v_sync(a_vs), .disp_ena(a_de),
    .column(a_col), .row(a_row), .frame_start(a_fs), .line_start(a_ls)
  );

  vga_timing_controller #(
    .H_PIXELS(8), .H_FP(1), .H_PULSE(2), .H_BP(1), .H_POL(1'b1),
    .V_PIXELS(4), .V_FP(1), .V_PULSE(1), .V_BP(1), .V_POL(1'b0)
  ) u_small (
    .clk(clk), .reset(reset), .enable(enable),
    .h_sync(b_hs), .v_sync(b_vs), .disp_ena(b_de),
    .column(b_col), .row(b_row), .frame_start(b_fs), .line_start(b_ls)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_exp(string tag, exp_t act, exp_t e);
    check({tag, ".h_sync"},      32'(act.hs),  32'(e.hs));
    check({tag, ".v_sync"},      32'(act.vs),  32'(e.vs));
    check({tag, ".disp_ena"},    32'(act.de),  32'(e.de));
    check({tag, ".column"},      act.col,      e.col);
    check({tag, ".row"},         act.row,      e.row);
    check({tag, ".frame_start"}, 32'(act.fs),  32'(e.fs));
    check({tag, ".line_start"},  32'(act.ls),  32'(e.ls));
  endtask

  // ---------------- reference model: position = pixel index within frame ----
  function automatic int line_len(timing_t t);
    return t.hpix + t.hfp + t.hpul + t.hbp;
  endfunction

  function automatic int frame_len(timing_t t);
    return line_len(t) * (t.vpix + t.vfp + t.vpul + t.vbp);
  endfunction

  function automatic exp_t reset_exp(timing_t t);
    exp_t r;
    r = '0;
    r.hs = !t.hpol;
    r.vs = !t.vpol;
    return r;
  endfunction

  function automatic exp_t model_step(timing_t t, int p, exp_t prev, bit en);
    exp_t r;
    int h, v;
    r = prev;
    r.fs = 1'b0;
    r.ls = 1'b0;
    if (!en) return r;
    h = p % line_len(t);
    v = p / line_len(t);
    r.hs = (h >= t.hpix + t.hfp && h < t.hpix + t.hfp + t.hpul) ? t.hpol : !t.hpol;
    r.vs = (v >= t.vpix + t.vfp && v < t.vpix + t.vfp + t.vpul) ? t.vpol : !t.vpol;
    r.de = (h < t.hpix) && (v < t.vpix);
    if (r.de) begin
      r.col = 32'(h);
      r.row = 32'(v);
    end
    r.fs = (p == 0);
    r.ls = (h == 0) && (v < t.vpix);
    return r;
  endfunction

  // ---------------- scoreboard ----------------------------------------------
  pair_t sb_q[$];
  timing_t ta, tb;
  int   pa, pb;
  exp_t ea, eb;
  logic agg_mark = 1'b0;

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      ea = reset_exp(ta);
      eb = reset_exp(tb);
      pa = 0;
      pb = 0;
    end else begin
      ea = model_step(ta, pa, ea, enable);
      eb = model_step(tb, pb, eb, enable);
      if (enable) begin
        pa = (pa + 1) % frame_len(ta);
        pb = (pb + 1) % frame_len(tb);
      end
    end
    sb_q.push_back({ea, eb, agg_mark});
    #1;
  endtask

  int agg_n = 0;
  int a_de_cnt = 0, a_hs_cnt = 0;
  int b_fs_cnt = 0, b_hs_cnt = 0, b_vs_cnt = 0;

  initial begin
    pair_t item;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        item = sb_q.pop_front();
        compare_exp("dflt", {a_hs, a_vs, a_de, a_col, a_row, a_fs, a_ls}, item.a);
        compare_exp("small", {b_hs, b_vs, b_de, b_col, b_row, b_fs, b_ls}, item.b);
        if (item.agg) begin
          if (agg_n < 800) begin
            a_de_cnt += int'(a_de);
            a_hs_cnt += int'(!a_hs);
          end
          if (agg_n < 840) begin
            b_fs_cnt += int'(b_fs);
            b_hs_cnt += int'(b_hs);
            b_vs_cnt += int'(!b_vs);
          end
          agg_n++;
        end
      end
    end
  end

  // ---------------- stimulus --------------------------------------------------
  initial begin
    ta = '{hpix:640, hfp:16, hpul:96, hbp:48, vpix:480, vfp:10, vpul:2, vbp:33,
           hpol:1'b0, vpol:1'b0};
    tb = '{hpix:8, hfp:1, hpul:2, hbp:1, vpix:4, vfp:1, vpul:1, vbp:1,
           hpol:1'b1, vpol:1'b0};
    pa = 0;
    pb = 0;
    ea = reset_exp(ta);
    eb = reset_exp(tb);

    repeat (3) tick();
    reset = 1'b0;
    enable = 1'b1;
    agg_mark = 1'b1;
    repeat (4300) tick();
    agg_mark = 1'b0;
    @(negedge clk);
    #1;
    check("line0_disp_ena_count", 32'(a_de_cnt), 32'd640);
    check("line0_hsync_active_count", 32'(a_hs_cnt), 32'd96);
    check("small_frame_start_count", 32'(b_fs_cnt), 32'd10);
    check("small_hsync_active_count", 32'(b_hs_cnt), 32'd140);
    check("small_vsync_active_count", 32'(b_vs_cnt), 32'd120);

    // Counters now hold h=300, v=5; assert reset between edges.
    reset = 1'b1;
    #1;
    compare_exp("async_reset_dflt", {a_hs, a_vs, a_de, a_col, a_row, a_fs, a_ls}, reset_exp(ta));
    compare_exp("async_reset_small", {b_hs, b_vs, b_de, b_col, b_row, b_fs, b_ls}, reset_exp(tb));
    repeat (2) tick();
    reset = 1'b0;

    repeat (150) tick();
    enable = 1'b0;
    repeat (10) tick();
    enable = 1'b1;

    repeat (6000) begin
      enable = ($urandom_range(0, 3) != 0);
      tick();
    end
    enable = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_controller.md
Name: vga_timing_controller

Overview:
- Generates VGA raster timing (h_sync, v_sync, disp_ena, column, row) for the pixel-domain image path.
- Directly drives hw_image_generator's disp_ena/row/column inputs and sends the sync outputs to the VGA DAC/connector.
- Runs on the pixel clock: one clk cycle is one pixel.
- All timing is set by parameters; defaults are 640x480@60 Hz (25.175 MHz).

Parameters:
- H_PIXELS, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_PULSE, 96, h_sync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- H_POL, 0, h_sync active level
- V_PIXELS, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_PULSE, 2, v_sync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- V_POL, 0, v_sync active level

Ports:
- clk  in  1  pixel clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- enable  in  1  advance timing when 1; freeze everything when 0
- h_sync  out  1  horizontal sync, polarity H_POL
- v_sync  out  1  vertical sync, polarity V_POL
- disp_ena  out  1  high while in the active display area
- column  out  32  active pixel x coordinate
- row  out  32  active pixel y coordinate
- frame_start  out  1  one-cycle pulse for pixel (0,0)
- line_start  out  1  one-cycle pulse for column 0 of each active line

Behaviour:
- Derived periods: H_PERIOD = H_PIXELS + H_FP + H_PULSE + H_BP (800); V_PERIOD = V_PIXELS + V_FP + V_PULSE + V_BP (525).
- Internal counters: h_count in 0..H_PERIOD-1, v_count in 0..V_PERIOD-1.
- Reset (async, any time, including mid-frame):
  - h_count = 0, v_count = 0
  - h_sync = ~H_POL, v_sync = ~V_POL
  - disp_ena = 0, column = 0, row = 0
  - frame_start = 0, line_start = 0
- Counter advance (rising clk edge with enable=1):
  - h_count wraps from H_PERIOD-1 to 0.
  - v_count increments on that same edge.
  - v_count wraps from V_PERIOD-1 to 0 on the edge where both counters are at their maxima.
- All outputs are registered from the pre-advance counter values, so outputs show counter state (h, v) one cycle after the counters held it (latency 1).
  - First edge after reset release, with enable=1: outputs reflect (0,0), so disp_ena=1, column=0, row=0, frame_start=1, line_start=1.
- Sync outputs:
  - h_sync = H_POL iff H_PIXELS+H_FP <= h < H_PIXELS+H_FP+H_PULSE; otherwise ~H_POL.
  - v_sync = V_POL iff V_PIXELS+V_FP <= v < V_PIXELS+V_FP+V_PULSE, evaluated over the whole line; otherwise ~V_POL.
- disp_ena = (h < H_PIXELS) && (v < V_PIXELS).
- column/row:
  - Load zero-extended h/v only when the pixel is active.
  - Hold their last values during blanking; no glitching to blank counts.
- Pulses:
  - frame_start = (h==0 && v==0).
  - line_start = (h==0 && v < V_PIXELS).
- enable=0: counters and all registered outputs hold. Held pulses are forced to 0, so no pulse repeats.
- Counter widths: clog2 of the period. Arithmetic is compared unsigned with no overflow beyond the wrap point.

Decomposition:
- Package vga_timing_pkg holds:
  - timing constants for 640x480@60 (defaults) and 800x600@60
  - derived H_PERIOD/V_PERIOD as localparams or functions
  - a clog2 helper
- One natural sub-module, vga_axis_counter, instantiated twice (horizontal, vertical). It contains:
  - a parameterised period counter with count-enable and wrap output
  - decodes for active, sync, and first-count
- The vertical instance is enabled by the horizontal wrap AND enable.

Test Plan:
- Reset asserted mid-line (h=300, v=5) -> same cycle: h_sync=1, v_sync=1, disp_ena=0, column=0, row=0. After release, first edge gives disp_ena=1, column=0, row=0, frame_start=1.
- Line 0 sweep -> disp_ena=1 for exactly 640 cycles, column 0..639. For the next 160 cycles disp_ena=0 and column holds 639. h_sync=0 for exactly the 96 outputs of h=656..751.
- Line wrap -> after the output for h=799, v=0, the next output is column=0, row=1, line_start=1, frame_start=0.
- Full frame -> v_sync=0 for exactly 1600 cycles (lines 490-491). frame_start recurs every 420000 cycles. row never exceeds 479.
- enable=0 for 10 cycles at column=100 -> all outputs frozen and pulses 0. After re-enable, column continues at 101.
- Non-default params (H_PIXELS=8, H_FP=1, H_PULSE=2, H_BP=1, V_PIXELS=4, V_FP=1, V_PULSE=1, V_BP=1, H_POL=1) -> line period 12 cycles, h_sync=1 only for h=9..10, frame period 84 cycles.
